mandel_engine: RTL

- One Mandelbrot iteration engine. NUM_PROC instances sit directly downstream of the coordinate generator.
- Each instance accepts an 83-bit coordinate word when selected and iterates z <= z^2 + c in signed Q8.24 fixed point until escape or MAX_ITER.
- It then raises done, which feeds the generator's one-hot cdones bus, and presents pixel position and iteration count to the frame-buffer writer.

---
 rtl/mandel_engine_pkg.sv | 26 ++
 rtl/mandel_fx_mul.sv | 19 +
 rtl/mandel_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mandel_engine_pkg.sv
// Shared constants and types for the Mandelbrot engines.
// Q8.24 fixed point, word layout and engine states.
package mandel_engine_pkg;

  localparam int NUM_PROC = 4;

  localparam int FRAC_BITS = 24;
  localparam logic [31:0] ESCAPE_R2 = 32'h0400_0000;

  localparam int X_PIX_LSB = 73;
  localparam int Y_PIX_LSB = 64;
  localparam int CX_LSB    = 32;
  localparam int CY_LSB    = 0;

  localparam int WORD_W = 83;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int FX_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    UPD  = 2'd2
  } state_e;

endpackage

// File: rtl/mandel_fx_mul.sv
// Signed Q8.24 multiply: 64-bit product, arithmetic
// shift by the fraction width, low 32 bits kept.
module mandel_fx_mul
  import mandel_engine_pkg::*;
(
  input  logic signed [FX_W-1:0] a,
  input  logic signed [FX_W-1:0] b,
  output logic signed [FX_W-1:0] p
);

  logic signed [63:0] prod;

  // Full-width product, then truncate toward -inf.
  always_comb begin
    prod = 64'(a) * 64'(b);
    p    = FX_W'(prod >>> FRAC_BITS);
  end

endmodule

// File: rtl/mandel_engine.sv
// One Mandelbrot iteration engine: z <= z^2 + c until
// escape or the iteration cap, then holds the result.
module mandel_engine
  import mandel_engine_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 2,
  parameter int ENGINE_ID    = 0,
  parameter int ITER_W       = 8,
  parameter int MAX_ITER     = 255
) (
  input  logic                    cclk,
  input  logic                    creset,
  input  logic                    latch_en,
  input  logic [C_ADDR_WIDTH-1:0] engine_addr,
  input  logic [WORD_W-1:0]       word_in,
  output logic                    done,
  output logic                    res_valid,
  output logic [X_W-1:0]          res_x,
  output logic [Y_W-1:0]          res_y,
  output logic [ITER_W-1:0]       res_iter
);

  state_e state_q, state_d;

  logic signed [FX_W-1:0] zr_q, zr_d;
  logic signed [FX_W-1:0] zi_q, zi_d;
  logic signed [FX_W-1:0] cx_q, cx_d;
  logic signed [FX_W-1:0] cy_q, cy_d;
  logic signed [FX_W-1:0] rr_q, rr_d;
  logic signed [FX_W-1:0] ii_q, ii_d;
  logic signed [FX_W-1:0] ri_q, ri_d;

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  logic [X_W-1:0]    res_x_q, res_x_d;
  logic [Y_W-1:0]    res_y_q, res_y_d;
  logic [ITER_W-1:0] res_iter_q, res_iter_d;
  logic              res_valid_q, res_valid_d;

  logic signed [FX_W-1:0] rr_w, ii_w, ri_w;
  logic signed [FX_W:0]   mag;
  logic                   esc;
  logic                   cap;
  logic                   hit;

  mandel_fx_mul u_mul_rr (.a(zr_q), .b(zr_q), .p(rr_w));
  mandel_fx_mul u_mul_ii (.a(zi_q), .b(zi_q), .p(ii_w));
  mandel_fx_mul u_mul_ri (.a(zr_q), .b(zi_q), .p(ri_w));

  // Escape test on the registered squares, and the accept match.
  always_comb begin
    mag = (FX_W+1)'(rr_q) + (FX_W+1)'(ii_q);
    esc = mag > $signed({1'b0, ESCAPE_R2});
    cap = iter_q == ITER_W'(MAX_ITER);
    hit = latch_en &&
          engine_addr == C_ADDR_WIDTH'(ENGINE_ID);
  end

  // Next-state and datapath updates for IDLE/MULT/UPD.
  always_comb begin
    state_d     = state_q;
    zr_d        = zr_q;
    zi_d        = zi_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    rr_d        = rr_q;
    ii_d        = ii_q;
    ri_d        = ri_q;
    x_d         = x_q;
    y_d         = y_q;
    iter_d      = iter_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_iter_d  = res_iter_q;
    res_valid_d = res_valid_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          x_d         = word_in[X_PIX_LSB +: X_W];
          y_d         = word_in[Y_PIX_LSB +: Y_W];
          cx_d        = word_in[CX_LSB +: FX_W];
          cy_d        = word_in[CY_LSB +: FX_W];
          zr_d        = '0;
          zi_d        = '0;
          iter_d      = '0;
          res_valid_d = 1'b0;
          state_d     = MULT;
        end
      end
      MULT: begin
        rr_d    = rr_w;
        ii_d    = ii_w;
        ri_d    = ri_w;
        state_d = UPD;
      end
      UPD: begin
        if (esc || cap) begin
          res_x_d     = x_q;
          res_y_d     = y_q;
          res_iter_d  = iter_q;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          zr_d    = rr_q - ii_q + cx_q;
          zi_d    = (ri_q <<< 1) + cy_q;
          iter_d  = iter_q + 1'b1;
          state_d = MULT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge cclk) begin
    if (creset) begin
      state_q     <= IDLE;
      zr_q        <= '0;
      zi_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      rr_q        <= '0;
      ii_q        <= '0;
      ri_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      iter_q      <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_iter_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      zr_q        <= zr_d;
      zi_q        <= zi_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      rr_q        <= rr_d;
      ii_q        <= ii_d;
      ri_q        <= ri_d;
      x_q         <= x_d;
      y_q         <= y_d;
      iter_q      <= iter_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_iter_q  <= res_iter_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign done      = state_q == IDLE;
  assign res_valid = res_valid_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_iter  = res_iter_q;

endmodule
